// File: rtl/chunked_ripple_adder_if.sv
// Operand/result handshake bundle for chunked_ripple_adder.
// Sub exists only when CHUNKED_ADDER_SUB_EN is defined.
interface chunked_ripple_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
`ifdef CHUNKED_ADDER_SUB_EN
  logic             Sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Z;
  logic             Cout;
  logic             V;

`ifdef CHUNKED_ADDER_SUB_EN
  modport master (output in_valid, A, B, Cin, Sub, out_ready,
                  input  in_ready, out_valid, Z, Cout, V);
  modport slave  (input  in_valid, A, B, Cin, Sub, out_ready,
                  output in_ready, out_valid, Z, Cout, V);
`else
  modport master (output in_valid, A, B, Cin, out_ready,
                  input  in_ready, out_valid, Z, Cout, V);
  modport slave  (input  in_valid, A, B, Cin, out_ready,
                  output in_ready, out_valid, Z, Cout, V);
`endif
endinterface

// File: rtl/chunked_ripple_adder.sv
// Multi-cycle ripple-carry adder summing CHUNK bits per clock through a registered carry.
// Optional subtract mode is enabled by defining CHUNKED_ADDER_SUB_EN.
module chunked_ripple_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  chunked_ripple_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunked_ripple_adder: CHUNK must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   z_q;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               cout_q;
  logic               v_q;
  logic               accept;
  logic               last_chunk;
  logic [IDX_W-1:0]   base;
  logic [CHUNK:0]     chunk_sum;
  logic               msb_carry_in;
  logic [WIDTH-1:0]   b_in;
  logic               cin_in;

`ifdef CHUNKED_ADDER_SUB_EN
  // Subtraction is A + ~B + 1, so the inversion and forced carry happen at capture.
  assign b_in   = bus.Sub ? ~bus.B : bus.B;
  assign cin_in = bus.Sub ? 1'b1 : bus.Cin;
`else
  assign b_in   = bus.B;
  assign cin_in = bus.Cin;
`endif

  assign accept     = (state == IDLE) && bus.in_valid;
  assign last_chunk = (cnt == CNT_W'(NCHUNK - 1));
  assign base       = IDX_W'(int'(cnt) * CHUNK);
  assign chunk_sum  = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                    + {{CHUNK{1'b0}}, carry};
  // Bit WIDTH-1 is the top bit of the final chunk; recover its carry-in from the sum bit.
  assign msb_carry_in = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ chunk_sum[CHUNK-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_chunk) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= bus.A;
      b_q <= b_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      carry  <= 1'b0;
      z_q    <= '0;
      cout_q <= 1'b0;
      v_q    <= 1'b0;
    end else if (accept) begin
      carry <= cin_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      z_q[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
      carry              <= chunk_sum[CHUNK];
      cnt                <= cnt + CNT_W'(1);
      if (last_chunk) begin
        cout_q <= chunk_sum[CHUNK];
        v_q    <= msb_carry_in ^ chunk_sum[CHUNK];
      end
    end
  end

  assign bus.Z    = z_q;
  assign bus.Cout = cout_q;
  assign bus.V    = v_q;
endmodule

// File: tb/tb_chunked_ripple_adder.sv
// Scoreboard bench for chunked_ripple_adder: 8/2 and 2/1 configurations against an integer model.
`timescale 1ns/1ps
module tb_chunked_ripple_adder;
  localparam int W    = 8;
  localparam int C    = 2;
  localparam int NCH  = W / C;
  localparam int W2   = 2;
  localparam int C2   = 1;
  localparam int NCH2 = W2 / C2;
`ifdef CHUNKED_ADDER_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  typedef struct {
    int z;
    int cout;
    int v;
    int t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chunked_ripple_adder_if #(.WIDTH(W))  bus();
  chunked_ripple_adder_if #(.WIDTH(W2)) bus2();

  chunked_ripple_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  chunked_ripple_adder #(.WIDTH(W2), .CHUNK(C2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ready_mode = 2;   // 0 random, 1 hold low, 2 hold high
  int   last_hs = -100;
  bit   mon_have = 1'b0;
  exp_t q[$];
  exp_t q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic, overflow judged by the signed result range.
  function automatic exp_t model(input int w, input int a, input int b, input int cin,
                                 input int sub, input int t);
    exp_t e;
    int   m, sa, sb, us, ss;
    m  = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (sub != 0) begin
      us     = a - b;
      ss     = sa - sb;
      e.cout = (a >= b) ? 1 : 0;
    end else begin
      us     = a + b + cin;
      ss     = sa + sb + cin;
      e.cout = (us >= m) ? 1 : 0;
    end
    e.z = (us + m) % m;
    e.v = (ss > m / 2 - 1 || ss < -(m / 2)) ? 1 : 0;
    e.t = t;
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(posedge clk);
    #3;
    case (ready_mode)
      0:       bus.out_ready = ($urandom_range(0, 9) < 7);
      1:       bus.out_ready = 1'b0;
      default: bus.out_ready = 1'b1;
    endcase
  end

  initial begin
    exp_t cur;
    bit   post;
    post = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_have = 1'b0;
        post     = 1'b0;
        continue;
      end
      if (post) begin
        check("in_ready_after_drain", bus.in_ready, 1);
        check("out_valid_one_shot", bus.out_valid, 0);
        post = 1'b0;
      end
      if (bus.out_valid) begin
        if (!mon_have) begin
          if (q.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
          end else begin
            cur      = q.pop_front();
            mon_have = 1'b1;
            check("latency", cyc - cur.t, NCH);
          end
        end
        if (mon_have) begin
          check("Z", bus.Z, cur.z);
          check("Cout", bus.Cout, cur.cout);
          check("V", bus.V, cur.v);
          check("in_ready_in_done", bus.in_ready, 0);
          if (bus.out_ready) begin
            mon_have = 1'b0;
            post     = 1'b1;
            last_hs  = cyc;
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus2.out_valid) begin
        if (q2.size() == 0) begin
          check("w2_unexpected_out_valid", 1, 0);
        end else begin
          e = q2.pop_front();
          check("w2_latency", cyc - e.t, NCH2);
          check("w2_Z", bus2.Z, e.z);
          check("w2_Cout", bus2.Cout, e.cout);
          check("w2_V", bus2.V, e.v);
        end
      end
    end
  end

  task automatic send(input int a, input int b, input int cin, input int sub,
                      input bit push, output int t_acc);
    int waited;
    waited = 0;
    t_acc  = -1;
    bus.A  = W'(a);
    bus.B  = W'(b);
    bus.Cin = cin[0];
`ifdef CHUNKED_ADDER_SUB_EN
    bus.Sub = sub[0];
`endif
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    t_acc = cyc;
    if (push) q.push_back(model(W, a, b, cin, HAS_SUB ? sub : 0, cyc));
    bus.in_valid = 1'b0;
  endtask

  task automatic send2(input int a, input int b, input int cin, input int sub);
    bus2.A   = W2'(a);
    bus2.B   = W2'(b);
    bus2.Cin = cin[0];
`ifdef CHUNKED_ADDER_SUB_EN
    bus2.Sub = sub[0];
`endif
    bus2.in_valid = 1'b1;
    @(negedge clk);
    check("w2_in_ready", bus2.in_ready, 1);
    @(posedge clk);
    #1;
    q2.push_back(model(W2, a, b, cin, HAS_SUB ? sub : 0, cyc));
    bus2.in_valid = 1'b0;
    repeat (NCH2 + 1) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || mon_have || q2.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", (q.size() != 0 || mon_have || q2.size() != 0), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_acc;
    int t_new;
    int n;
    int sub;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Cin       = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.A        = '0;
    bus2.B        = '0;
    bus2.Cin      = 1'b0;
    bus2.out_ready = 1'b1;
`ifdef CHUNKED_ADDER_SUB_EN
    bus.Sub  = 1'b0;
    bus2.Sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_Z", bus.Z, 0);
    check("rst_Cout", bus.Cout, 0);
    check("rst_V", bus.V, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_w2_in_ready", bus2.in_ready, 1);
    @(posedge clk);
    #1;

    // WIDTH=2, CHUNK=1: every operand combination
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          send2(a, b, c, 0);
    if (HAS_SUB)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++)
          send2(a, b, 0, 1);
    drain();

    ready_mode = 2;
    send(8'h7F, 8'h01, 0, 0, 1'b1, t_acc);
    send(8'hFF, 8'h01, 1, 0, 1'b1, t_acc);
    send(8'h00, 8'h00, 0, 0, 1'b1, t_acc);
    send(8'h80, 8'h80, 1, 0, 1'b1, t_acc);
    if (HAS_SUB) begin
      send(8'h05, 8'h07, 1, 1, 1'b1, t_acc);
      send(8'h80, 8'h01, 0, 1, 1'b1, t_acc);
      send(8'h33, 8'h33, 0, 1, 1'b1, t_acc);
    end
    drain();

    // Backpressure: result must hold and new operands must wait for the handshake.
    ready_mode = 1;
    @(posedge clk);
    #1;
    send(8'hA5, 8'h5A, 1, 0, 1'b1, t_acc);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", bus.out_valid, 1);
    @(posedge clk);
    #1;
    bus.A = 8'h12;
    bus.B = 8'h34;
    bus.Cin = 1'b0;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    ready_mode = 2;
    send(8'h12, 8'h34, 0, 0, 1'b1, t_new);
    check("bp_accept_after_handshake", (t_new >= last_hs + 2), 1);
    drain();

    // Reset two cycles into RUN aborts the operation.
    send(8'h55, 8'h22, 0, 0, 1'b0, t_acc);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_Z", bus.Z, 0);
    check("abort_Cout", bus.Cout, 0);
    check("abort_V", bus.V, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready", bus.in_ready, 1);
    repeat (8) @(posedge clk);
    #1;
    send(8'h10, 8'h20, 0, 0, 1'b1, t_acc);
    drain();

    // Random operands, random consumer readiness and issue gaps.
    ready_mode = 0;
    for (int i = 0; i < 150; i++) begin
      sub = HAS_SUB ? int'($urandom_range(0, 1)) : 0;
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 1)), sub, 1'b1, t_acc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    ready_mode = 2;
    drain();
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
